// File: rtl/irq_pending_latch_if.sv
// ----------------------------------------------------------------------------
// irq_pending_latch_if
// Bundle of the request/encoder/CPU handshake signals around irq_pending_latch.
//   irq        raw request lines (synchronous to clk)
//   mask_wr    mask write strobe, mask_data = new mask (1 = line masked)
//   pend_vec   masked pending vector towards the priority encoder
//   enc_id     encoder index, enc_valid = encoder any-valid
//   int_req    interrupt request to core, int_id = its index
//   int_ack    core acknowledge pulse, eoi = core end-of-interrupt pulse
//   busy       interrupt in service
// master: the surrounding system (pins, encoder, core); slave: the latch.
// ----------------------------------------------------------------------------
interface irq_pending_latch_if #(
  parameter int N    = 8,
  parameter int ID_W = 3
);
  logic [N-1:0]    irq;
  logic            mask_wr;
  logic [N-1:0]    mask_data;
  logic [N-1:0]    pend_vec;
  logic [ID_W-1:0] enc_id;
  logic            enc_valid;
  logic            int_req;
  logic [ID_W-1:0] int_id;
  logic            int_ack;
  logic            eoi;
  logic            busy;

  modport master (
    output irq, mask_wr, mask_data, enc_id, enc_valid, int_ack, eoi,
    input  pend_vec, int_req, int_id, busy
  );

  modport slave (
    input  irq, mask_wr, mask_data, enc_id, enc_valid, int_ack, eoi,
    output pend_vec, int_req, int_id, busy
  );
endinterface

// File: rtl/irq_pending_latch.sv
// ----------------------------------------------------------------------------
// irq_pending_latch
// Rising-edge interrupt capture with pending bits, software mask and a
// request/acknowledge/end-of-interrupt handshake towards the core. The masked
// pending vector feeds an external priority encoder whose index/valid come
// back combinationally in the same cycle.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   irq_pending_latch_if.slave (see interface header for signals)
// ----------------------------------------------------------------------------
module irq_pending_latch #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  irq_pending_latch_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t          state_q,   state_d;
  logic [N-1:0]    irq_q,     irq_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    mask_q,    mask_d;
  logic            int_req_q, int_req_d;
  logic [ID_W-1:0] int_id_q,  int_id_d;
  logic            busy_q,    busy_d;

  logic [N-1:0]    rise_s;
  logic [N-1:0]    clr_s;

  // Edge detect, pending update and mask register next-state.
  always_comb begin
    irq_d  = bus.irq;
    rise_s = bus.irq & ~irq_q;
    if (bus.mask_wr) begin
      mask_d = bus.mask_data;
    end else begin
      mask_d = mask_q;
    end
    // Clear first, then set: an edge arriving on the ack cycle survives.
    pending_d = (pending_q & ~clr_s) | rise_s;
  end

  // Handshake FSM next-state and registered-output next values.
  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    int_id_d  = int_id_q;
    busy_d    = busy_q;
    clr_s     = {N{1'b0}};
    case (state_q)
      IDLE: begin
        if (bus.enc_valid) begin
          int_id_d  = bus.enc_id;
          int_req_d = 1'b1;
          state_d   = REQ;
        end else begin
          state_d   = IDLE;
        end
      end
      REQ: begin
        // int_id is frozen here; the ack clears that line even if it has
        // been masked since the request was committed.
        if (bus.int_ack) begin
          clr_s     = {{(N-1){1'b0}}, 1'b1} << int_id_q;
          int_req_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = SERV;
        end else begin
          state_d   = REQ;
        end
      end
      SERV: begin
        if (bus.eoi) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = SERV;
        end
      end
      default: begin
        int_req_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_q     <= {N{1'b0}};
      pending_q <= {N{1'b0}};
      mask_q    <= {N{1'b0}};
      int_req_q <= 1'b0;
      int_id_q  <= {ID_W{1'b0}};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
      busy_q    <= busy_d;
    end
  end

  // pend_vec comes straight from registers so the encoder sees it in the
  // same cycle the pending bit is set.
  assign bus.pend_vec = pending_q & ~mask_q;
  assign bus.int_req  = int_req_q;
  assign bus.int_id   = int_id_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream request stage for the 8-input priority encoder.
- Detects rising edges on raw interrupt lines, holds them as pending bits, and applies a software mask.
- Presents the masked pending vector to the encoder, takes the encoder's index/valid back, and runs a request/acknowledge/end-of-interrupt handshake with the CPU side.
- Sits between the synchronised IRQ pins and the encoder; its int_req/int_id outputs go to the core.

Parameters:
- N, 8, number of request lines (must match encoder input width).
- ID_W, 3, width of the interrupt index (log2 N).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- irq  input  N  raw request lines, already synchronous to clk.
- mask_wr  input  1  mask write strobe.
- mask_data  input  N  new mask value, 1 = line masked.
- pend_vec  output  N  masked pending vector, drives encoder y.
- enc_id  input  ID_W  encoder index output (out).
- enc_valid  input  1  encoder any-valid output (d).
- int_req  output  1  interrupt request to core.
- int_id  output  ID_W  index of the requested interrupt, stable while int_req=1.
- int_ack  input  1  core acknowledge, single-cycle pulse.
- eoi  input  1  core end-of-interrupt, single-cycle pulse.
- busy  output  1  interrupt in service (ack received, eoi not yet received).

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: irq_q=0, pending=0, mask=0 (all lines enabled), pend_vec=0, int_req=0, int_id=0, busy=0, state=IDLE.
  - Reset mid-operation discards all pending and in-service state.
- Edge detect:
  - irq_q <= irq every cycle; edge = irq & ~irq_q.
  - Because irq_q resets to 0, a line held high across reset registers one edge on the first post-reset cycle.
  - Level-high without a new edge does not re-pend a line.
- Pending register: pending <= (pending & ~clr) | edge.
  - clr is the one-hot of int_id, applied only on the accepted int_ack cycle.
  - Set wins: a new edge on the same bit in the ack cycle leaves the bit pending.
- Mask: mask <= mask_data when mask_wr=1, effective the next cycle.
  - Masking does not clear pending bits; unmasking later exposes them again.
- pend_vec = pending & ~mask, purely combinational from registers, with no extra latency.
  - The encoder's enc_id/enc_valid are treated as combinational from pend_vec within the same cycle.
- FSM (3 states):
  - IDLE: if enc_valid=1 -> int_id <= enc_id, int_req <= 1, go REQ.
  - REQ: int_req=1 and int_id frozen.
    - Higher-priority arrivals, mask writes and enc_id changes do not alter int_id or drop int_req.
    - On int_ack=1 -> clear pending[int_id], int_req <= 0, busy <= 1, go SERV.
  - SERV: new edges keep accumulating in pending; the FSM does not issue a new request.
    - On eoi=1 -> busy <= 0, go IDLE.
- Ignored inputs: int_ack outside REQ and eoi outside SERV.
- Latency:
  - irq rises before edge k -> pend_vec bit high after edge k -> int_req high after edge k+1.
  - After eoi at edge m, a still-pending request re-asserts int_req after edge m+1.
- Acked-while-masked: if a line is masked while in REQ, the ack still clears that pending bit (the request was already committed).

Test Plan:
- Single request: reset, irq=8'h04 from cycle 2 -> pend_vec=8'h04 after 1 edge, int_req=1 with int_id=2 one edge later; ack -> pend_vec=0, busy=1; eoi -> busy=0, int_req stays 0.
- Priority and queueing: irq=8'h81 in the same cycle -> int_id=7; ack+eoi -> int_req reasserts with int_id=0 one cycle after eoi.
- No preemption: in REQ with int_id=1, raise irq[6] -> int_id stays 1, pend_vec=8'h42; after ack+eoi -> int_id=6.
- Masking: mask_wr with 8'h08, then pulse irq[3] -> pend_vec=0, int_req=0; write mask 8'h00 -> pend_vec=8'h08, int_req=1 with int_id=3.
- Ack/edge collision: in REQ with int_id=5, drop then raise irq[5] so its edge lands on the int_ack cycle -> after eoi, int_req reasserts with int_id=5.
- Reset mid-service: in SERV with pending=8'h30, assert rst one cycle -> all outputs 0, state IDLE; with irq held at 8'h30 through reset -> int_id=5 two edges after reset release.
